// File: rtl/lvl_state_table.sv
// lvl_state_table: per-decision-level {dcd_bin, has_bkt} store with a
// built-in backtrack-level search and single-edge backtrack commit.
// Optional macro LVL_STATE_PARALLEL_FIND_EN: when defined, the search
// resolves in a single cycle with a priority encoder instead of a
// one-level-per-cycle downward scan.
module lvl_state_table #(
  parameter int NUM_LVLS         = 16,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN_ID     = 10,
  parameter int WIDTH_LVL_STATES = WIDTH_BIN_ID + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dcd_valid_i,
  input  logic [WIDTH_LVL-1:0]        cur_lvl_i,
  input  logic [WIDTH_BIN_ID-1:0]     cur_bin_num_i,
  input  logic                        find_start_i,
  input  logic [WIDTH_LVL-1:0]        max_lvl_i,
  output logic                        busy_o,
  output logic                        find_done_o,
  output logic                        find_found_o,
  output logic [WIDTH_LVL-1:0]        bkt_lvl_o,
  output logic [WIDTH_BIN_ID-1:0]     bkt_bin_o,
  input  logic                        apply_bkt_i,
  input  logic                        wr_en_i,
  input  logic [WIDTH_LVL-1:0]        wr_lvl_i,
  input  logic [WIDTH_LVL_STATES-1:0] wr_state_i,
  input  logic [WIDTH_LVL-1:0]        rd_lvl_i,
  output logic [WIDTH_LVL_STATES-1:0] rd_state_o
);

  localparam int PTR_W = $clog2(NUM_LVLS);
  localparam logic [WIDTH_LVL-1:0] TOP_LVL = WIDTH_LVL'(NUM_LVLS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  logic [NUM_LVLS-1:0][WIDTH_LVL_STATES-1:0] entries;
  logic [NUM_LVLS-1:0]                       has_bkt;

  state_t                  state_reg, state_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic                    done_reg, done_next;
  logic                    found_reg, found_next;
  logic [WIDTH_LVL-1:0]    lvl_reg, lvl_next;
  logic [WIDTH_BIN_ID-1:0] bin_reg, bin_next;
  logic                    apply_en;
  logic [PTR_W-1:0]        start_ptr;

  // Requests above the table clamp to the top stored level.
  assign start_ptr = (max_lvl_i >= TOP_LVL) ? PTR_W'(NUM_LVLS - 1) : max_lvl_i[PTR_W-1:0];

  // One register per level so a backtrack can clear every level above the
  // target in a single edge; apply beats load writes, which beat decides.
  for (genvar gi = 0; gi < NUM_LVLS; gi++) begin : g_lvl
    localparam logic [WIDTH_LVL-1:0] MY_LVL = WIDTH_LVL'(gi);
    logic [WIDTH_LVL_STATES-1:0] entry_reg;

    // Per-level entry update in priority order.
    always_ff @(posedge clk) begin
      if (rst) begin
        entry_reg <= '0;
      end else if (apply_en && (MY_LVL == lvl_reg)) begin
        entry_reg[0] <= 1'b1;
      end else if (apply_en && (MY_LVL > lvl_reg)) begin
        entry_reg <= '0;
      end else if (wr_en_i && (wr_lvl_i == MY_LVL)) begin
        entry_reg <= wr_state_i;
      end else if (dcd_valid_i && (cur_lvl_i == MY_LVL)) begin
        entry_reg <= {cur_bin_num_i, 1'b0};
      end
    end

    assign entries[gi] = entry_reg;
    assign has_bkt[gi] = entry_reg[0];
  end

  // Registered read of the pre-edge contents; out-of-range levels read as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_o <= '0;
    end else if (rd_lvl_i <= TOP_LVL) begin
      rd_state_o <= entries[rd_lvl_i[PTR_W-1:0]];
    end else begin
      rd_state_o <= '0;
    end
  end

`ifdef LVL_STATE_PARALLEL_FIND_EN
  logic             hit;
  logic [PTR_W-1:0] hit_lvl;

  // Highest level in [1..ptr] without has_bkt; ascending loop so the last hit wins.
  always_comb begin
    hit     = 1'b0;
    hit_lvl = '0;
    for (int i = 1; i < NUM_LVLS; i++) begin
      if ((PTR_W'(i) <= ptr_reg) && !has_bkt[i]) begin
        hit     = 1'b1;
        hit_lvl = PTR_W'(i);
      end
    end
  end
`endif

  // FSM state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      done_reg  <= 1'b0;
      found_reg <= 1'b0;
      lvl_reg   <= '0;
      bin_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      done_reg  <= done_next;
      found_reg <= found_next;
      lvl_reg   <= lvl_next;
      bin_reg   <= bin_next;
    end
  end

  // Next-state logic: search, result capture and backtrack commit.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    done_next  = 1'b0;
    found_next = found_reg;
    lvl_next   = lvl_reg;
    bin_next   = bin_reg;
    apply_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (find_start_i) begin
          state_next = SCAN;
          ptr_next   = start_ptr;
        end
      end
      SCAN: begin
`ifdef LVL_STATE_PARALLEL_FIND_EN
        state_next = DONE;
        done_next  = 1'b1;
        found_next = hit;
        lvl_next   = WIDTH_LVL'(hit_lvl);
        bin_next   = hit ? entries[hit_lvl][WIDTH_BIN_ID:1] : '0;
`else
        if (!has_bkt[ptr_reg] && (ptr_reg != '0)) begin
          state_next = DONE;
          done_next  = 1'b1;
          found_next = 1'b1;
          lvl_next   = WIDTH_LVL'(ptr_reg);
          bin_next   = entries[ptr_reg][WIDTH_BIN_ID:1];
        end else if (ptr_reg == '0) begin
          // Level 0 is the root and never a backtrack target.
          state_next = DONE;
          done_next  = 1'b1;
          found_next = 1'b0;
          lvl_next   = '0;
          bin_next   = '0;
        end else begin
          ptr_next = ptr_reg - PTR_W'(1);
        end
`endif
      end
      DONE: begin
        if (found_reg && apply_bkt_i) begin
          apply_en   = 1'b1;
          state_next = IDLE;
        end else if (find_start_i || !found_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o       = (state_reg != IDLE);
  assign find_done_o  = done_reg;
  assign find_found_o = found_reg;
  assign bkt_lvl_o    = lvl_reg;
  assign bkt_bin_o    = bin_reg;

endmodule

// File: tb/tb_lvl_state_table.sv
// tb_lvl_state_table: scoreboard bench for lvl_state_table. Reads and searches
// push expected results from a reference level table; they are popped and
// compared when the DUT produces the read data or the done pulse.
module tb_lvl_state_table;

  logic        clk;
  logic        rst;
  logic        dcd_valid;
  logic [15:0] cur_lvl;
  logic [9:0]  cur_bin;
  logic        find_start;
  logic [15:0] max_lvl;
  logic        busy;
  logic        find_done;
  logic        find_found;
  logic [15:0] bkt_lvl;
  logic [9:0]  bkt_bin;
  logic        apply_bkt;
  logic        wr_en;
  logic [15:0] wr_lvl;
  logic [10:0] wr_state;
  logic [15:0] rd_lvl;
  logic [10:0] rd_state;

  typedef struct {
    logic        found;
    logic [15:0] lvl;
    logic [9:0]  bin;
    int          lat;
  } find_exp_t;

  logic [10:0] mdl [16];
  logic [10:0] rd_q [$];
  find_exp_t   find_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  lvl_state_table dut (
    .clk          (clk),
    .rst          (rst),
    .dcd_valid_i  (dcd_valid),
    .cur_lvl_i    (cur_lvl),
    .cur_bin_num_i(cur_bin),
    .find_start_i (find_start),
    .max_lvl_i    (max_lvl),
    .busy_o       (busy),
    .find_done_o  (find_done),
    .find_found_o (find_found),
    .bkt_lvl_o    (bkt_lvl),
    .bkt_bin_o    (bkt_bin),
    .apply_bkt_i  (apply_bkt),
    .wr_en_i      (wr_en),
    .wr_lvl_i     (wr_lvl),
    .wr_state_i   (wr_state),
    .rd_lvl_i     (rd_lvl),
    .rd_state_o   (rd_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog in case a wait is ever missed.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decide(input int l, input int b);
    dcd_valid = 1'b1;
    cur_lvl   = 16'(l);
    cur_bin   = 10'(b);
    tick();
    dcd_valid = 1'b0;
    if (l < 16) mdl[l] = {10'(b), 1'b0};
  endtask

  task automatic write_lvl(input int l, input logic [10:0] s);
    wr_en    = 1'b1;
    wr_lvl   = 16'(l);
    wr_state = s;
    tick();
    wr_en = 1'b0;
    if (l < 16) mdl[l] = s;
  endtask

  task automatic read_lvl(input int l);
    logic [10:0] e;
    rd_lvl = 16'(l);
    rd_q.push_back(mdl[l]);
    tick();
    e = rd_q.pop_front();
    $display("read lvl=%0d data=%0h expect=%0h", l, rd_state, e);
    check_val($sformatf("rd_lvl%0d", l), 32'(rd_state), 32'(e));
  endtask

  function automatic find_exp_t model_find(input int m);
    find_exp_t e;
    int s;
    int res;
    s = (m > 15) ? 15 : m;
    res = 0;
    e.found = 1'b0;
    e.lvl = '0;
    e.bin = '0;
    for (int l = s; l >= 1; l--) begin
      if (mdl[l][0] == 1'b0) begin
        e.found = 1'b1;
        e.lvl   = 16'(l);
        e.bin   = mdl[l][10:1];
        res     = l;
        break;
      end
    end
`ifdef LVL_STATE_PARALLEL_FIND_EN
    e.lat = 1;
`else
    e.lat = s - res + 1;
`endif
    return e;
  endfunction

  // Start a search and wait (bounded) for its done pulse; leaves the DUT in DONE.
  task automatic run_find(input int m);
    find_exp_t e;
    int n;
    find_start = 1'b1;
    max_lvl    = 16'(m);
    find_q.push_back(model_find(m));
    tick();
    find_start = 1'b0;
    check_val("busy_scan", 32'(busy), 32'd1);
    n = 0;
    while (!find_done && n < 40) begin
      tick();
      n++;
    end
    e = find_q.pop_front();
    if (!find_done) begin
      check_val("find_timeout", 32'(find_done), 32'd1);
    end else begin
      $display("find max=%0d cycles=%0d found=%0d lvl=%0d bin=%0d", m, n, find_found, bkt_lvl, bkt_bin);
      check_val("find_lat", 32'(n), 32'(e.lat));
      check_val("find_found", 32'(find_found), 32'(e.found));
      check_val("bkt_lvl", 32'(bkt_lvl), 32'(e.lvl));
      check_val("bkt_bin", 32'(bkt_bin), 32'(e.bin));
    end
  endtask

  task automatic apply_model();
    int b;
    b = int'(bkt_lvl);
    mdl[b][0] = 1'b1;
    for (int l = b + 1; l < 16; l++) mdl[l] = '0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1; dcd_valid = 1'b0; cur_lvl = '0; cur_bin = '0;
    find_start = 1'b0; max_lvl = '0; apply_bkt = 1'b0;
    wr_en = 1'b0; wr_lvl = '0; wr_state = '0; rd_lvl = '0;
    for (int l = 0; l < 16; l++) mdl[l] = '0;
    tick();
    tick();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(find_done), 32'd0);
    check_val("rst_found", 32'(find_found), 32'd0);
    check_val("rst_bkt_lvl", 32'(bkt_lvl), 32'd0);
    check_val("rst_bkt_bin", 32'(bkt_bin), 32'd0);
    check_val("rst_rd_state", 32'(rd_state), 32'd0);
    rst = 1'b0;
    for (int l = 0; l < 16; l++) read_lvl(l);

    // Decide levels 1..4, mark level 4 backtracked, then search from 4.
    for (int l = 1; l <= 4; l++) decide(l, l + 4);
    write_lvl(4, {10'd8, 1'b1});
    // Read during a same-cycle decide returns the old contents.
    rd_lvl = 16'd5;
    rd_q.push_back(mdl[5]);
    dcd_valid = 1'b1; cur_lvl = 16'd5; cur_bin = 10'd11;
    tick();
    dcd_valid = 1'b0;
    mdl[5] = {10'd11, 1'b0};
    check_val("rd_no_wt", 32'(rd_state), 32'(rd_q.pop_front()));
    read_lvl(5);
    run_find(4);

    // Commit with colliding writes: the load at a cleared level is dropped,
    // the decide below the target lands.
    apply_bkt = 1'b1;
    wr_en = 1'b1; wr_lvl = 16'd4; wr_state = {10'd20, 1'b0};
    dcd_valid = 1'b1; cur_lvl = 16'd2; cur_bin = 10'd9;
    apply_model();
    tick();
    apply_bkt = 1'b0; wr_en = 1'b0; dcd_valid = 1'b0;
    mdl[2] = {10'd9, 1'b0};
    check_val("idle_after_apply", 32'(busy), 32'd0);
    for (int l = 0; l <= 5; l++) read_lvl(l);

    // All of 1..3 backtracked: no target, apply is ignored.
    for (int l = 1; l <= 3; l++) write_lvl(l, {mdl[l][10:1], 1'b1});
    run_find(3);
    apply_bkt = 1'b1;
    tick();
    check_val("notfound_idle", 32'(busy), 32'd0);
    check_val("done_single", 32'(find_done), 32'd0);
    tick();
    apply_bkt = 1'b0;
    // Out-of-range writes are ignored.
    decide(20, 77);
    write_lvl(16, {10'd55, 1'b0});
    for (int l = 0; l <= 4; l++) read_lvl(l);

    // Oversized max_lvl clamps to level 15.
    run_find(100);
    find_start = 1'b1;
    tick();
    find_start = 1'b0;
    check_val("start_in_done_idle", 32'(busy), 32'd0);
    decide(9, 33);
    for (int l = 10; l <= 15; l++) write_lvl(l, {10'(64 + l), 1'b1});
    run_find(100);
    apply_bkt = 1'b1;
    apply_model();
    tick();
    apply_bkt = 1'b0;
    read_lvl(9);
    read_lvl(10);
    read_lvl(15);

    // Reset during a search: no done pulse, table cleared.
    for (int l = 4; l <= 15; l++) write_lvl(l, {10'(l), 1'b1});
    find_start = 1'b1;
    max_lvl = 16'd100;
    tick();
    find_start = 1'b0;
    check_val("busy_pre_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int l = 0; l < 16; l++) mdl[l] = '0;
    pulses = 0;
    repeat (20) begin
      if (find_done) pulses++;
      tick();
    end
    check_val("no_done_after_rst", 32'(pulses), 32'd0);
    check_val("busy_after_rst", 32'(busy), 32'd0);
    for (int l = 0; l < 16; l++) read_lvl(l);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
